serial_word_capture: RTL and testbench

- Serial-in, parallel-out receiver. Assembles WIDTH-bit words from a qualified serial bit stream.
- Counterpart to the team's parallel-load/rotate shift register, which serialises words; this block deserialises them.
- Selectable bit order per word; the output word is double-buffered with a valid/ready handshake and a sticky overrun flag.
- Sits between a board-level serial source (switch/key-driven or another shifter's Q[0]/Q[7]) and LEDR display logic.

---
 rtl/serial_word_capture.sv | 164 ++++++++++++++++
 tb/tb_serial_word_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_capture.sv
// serial_word_capture: serial-in, parallel-out word receiver.
// Assembles WIDTH-bit words from a bit_valid-qualified serial stream. The bit
// order is chosen per word. The finished word goes to a double-buffered
// data_out with a valid/ready handshake. A sticky overrun flag records any word
// that was dropped because the consumer had not yet taken the previous one.
// Optional feature macro: SERIAL_CAPTURE_PARITY_EN. When it is defined, one
// even-parity bit follows the data bits and its check result goes to parity_err.
// When it is not defined, parity_err is tied low.
module serial_word_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             msb_first,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             data_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SERIAL_CAPTURE_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               order_q, order_d;   // 1: MSB first for the current word
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   word;
  logic               last_bit;
  logic               complete;
  logic               load;
  logic               drop;
`ifdef SERIAL_CAPTURE_PARITY_EN
  logic               word_par;
`endif

  // Shift the register by one bit in the order that was latched at start.
  assign shifted  = order_q ? {sreg_q[WIDTH-2:0], serial_in}
                            : {serial_in, sreg_q[WIDTH-1:1]};
  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  // Compute the next state and the shift datapath. Raise 'complete' on the
  // edge that finishes a word.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path can infer a latch.
    state_d  = state_q;
    sreg_d   = sreg_q;
    count_d  = count_q;
    order_d  = order_q;
    complete = 1'b0;
    word     = shifted;
`ifdef SERIAL_CAPTURE_PARITY_EN
    word_par = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // bit_valid is ignored here, including in the start cycle itself.
        if (start) begin
          state_d = SHIFT;
          count_d = '0;
          order_d = msb_first;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          sreg_d  = shifted;
          count_d = count_q + CNT_W'(1);
          if (last_bit) begin
`ifdef SERIAL_CAPTURE_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = IDLE;
            complete = 1'b1;
`endif
          end
        end
      end
`ifdef SERIAL_CAPTURE_PARITY_EN
      PARITY: begin
        // The data bits are already in place. This edge samples the parity bit.
        if (bit_valid) begin
          state_d  = IDLE;
          complete = 1'b1;
          word     = sreg_q;
          word_par = (^sreg_q) ^ serial_in;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Decide at completion whether the output buffer accepts the word or drops it.
  assign load = complete && (!data_valid || data_ready);
  assign drop = complete && data_valid && !data_ready;

  // Register the receiver control state. A reset in the middle of a word discards the partial bits.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      count_q <= '0;
      order_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      order_q <= order_d;
    end
  end

  // Output buffer and handshake. A completing word has priority over a plain consume.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (load) begin
      data_out   <= word;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky overrun flag. A drop in the same cycle as clear_overrun wins over the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef SERIAL_CAPTURE_PARITY_EN
  // parity_err describes data_out, so it changes only when data_out loads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= word_par;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_word_capture.sv
// tb_serial_word_capture: directed, table-driven bench for serial_word_capture.
// Inputs change 1 time unit after each rising edge. Outputs are sampled at the
// same point. SERIAL_CAPTURE_PARITY_EN selects the parity build.
module tb_serial_word_capture;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, msb_first, serial_in, bit_valid, data_ready, clear_overrun;
  logic [7:0] data_out;
  logic       data_valid, busy, overrun, parity_err;

  int n_pass  = 0;
  int n_total = 0;

  serial_word_capture #(.WIDTH(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .msb_first     (msb_first),
    .serial_in     (serial_in),
    .bit_valid     (bit_valid),
    .data_ready    (data_ready),
    .clear_overrun (clear_overrun),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .busy          (busy),
    .overrun       (overrun),
    .parity_err    (parity_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       msb;
    logic [7:0] seq;      // transmitted seq[7] first
    int         gap;      // a gap of up to this many idle cycles follows each bit
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic put_bit(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Send one full word. In the parity build the correct even-parity bit is appended.
  task automatic send_word(input logic msb, input logic [7:0] seq, input int gap,
                           input bit ready_last, input bit start_mid, input bit bv_with_start);
    start     = 1'b1;
    msb_first = msb;
    if (bv_with_start) begin
      bit_valid = 1'b1;
      serial_in = 1'b1;
    end
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) check("busy_before_last_bit", busy, 1);
      serial_in = seq[i];
      bit_valid = 1'b1;
      start     = start_mid && (i == 4);
`ifndef SERIAL_CAPTURE_PARITY_EN
      if (i == 0) data_ready = ready_last;
`endif
      tick();
      bit_valid  = 1'b0;
      start      = 1'b0;
      data_ready = 1'b0;
      repeat (i % (gap + 1)) tick();
    end
`ifdef SERIAL_CAPTURE_PARITY_EN
    check("busy_before_parity_bit", busy, 1);
    serial_in  = ^seq;
    bit_valid  = 1'b1;
    data_ready = ready_last;
    tick();
    bit_valid  = 1'b0;
    data_ready = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;

    vecs[0] = '{msb: 1'b1, seq: 8'hB2, gap: 0, exp_out: 8'hB2};
    vecs[1] = '{msb: 1'b0, seq: 8'hB2, gap: 0, exp_out: 8'h4D};
    vecs[2] = '{msb: 1'b1, seq: 8'h00, gap: 1, exp_out: 8'h00};
    vecs[3] = '{msb: 1'b0, seq: 8'h80, gap: 2, exp_out: 8'h01};
    vecs[4] = '{msb: 1'b1, seq: 8'hFF, gap: 3, exp_out: 8'hFF};
    vecs[5] = '{msb: 1'b0, seq: 8'h0F, gap: 1, exp_out: 8'hF0};

    reset_n = 1'b0; start = 1'b0; msb_first = 1'b0; serial_in = 1'b0;
    bit_valid = 1'b0; data_ready = 1'b0; clear_overrun = 1'b0;
    tick();
    tick();
    check("reset_data_out", data_out, 0);
    check("reset_data_valid", data_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_parity_err", parity_err, 0);
    reset_n = 1'b1;
    tick();

    // Table-driven single words with a consume after each word.
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].msb, vecs[v].seq, vecs[v].gap, 1'b0, 1'b0, 1'b0);
      check("vec_data_out", data_out, vecs[v].exp_out);
      check("vec_data_valid", data_valid, 1);
      check("vec_busy_after", busy, 0);
      check("vec_overrun", overrun, 0);
      check("vec_parity_err", parity_err, 0);
      consume();
      check("vec_consumed_valid", data_valid, 0);
      check("vec_consumed_hold", data_out, vecs[v].exp_out);
    end

    // Overrun: the second word is dropped while the first is still waiting.
    send_word(1'b1, 8'hB2, 0, 1'b0, 1'b0, 1'b0);
    send_word(1'b1, 8'h0F, 0, 1'b0, 1'b0, 1'b0);
    check("ovr_data_out_kept", data_out, 8'hB2);
    check("ovr_flag_set", overrun, 1);
    check("ovr_valid_still", data_valid, 1);
    consume();
    check("ovr_consumed_valid", data_valid, 0);
    check("ovr_flag_sticky", overrun, 1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);

    // A drop wins over clear_overrun when both happen in the same cycle.
    send_word(1'b1, 8'h33, 0, 1'b0, 1'b0, 1'b0);
    clear_overrun = 1'b1;
    send_word(1'b1, 8'h44, 0, 1'b0, 1'b0, 1'b0);
    check("set_wins_overrun", overrun, 1);
    check("set_wins_data_out", data_out, 8'h33);
    tick();
    clear_overrun = 1'b0;
    check("set_wins_then_clear", overrun, 0);

    // Gaps between bits, start pulsed in the middle of the word, and data_ready
    // on the completion edge while data_valid is already set.
    send_word(1'b1, 8'h55, 3, 1'b1, 1'b1, 1'b0);
    check("gap_data_out", data_out, 8'h55);
    check("gap_valid_kept", data_valid, 1);
    check("gap_no_overrun", overrun, 0);

    // A reset in the middle of a word discards the partial bits.
    start = 1'b1; msb_first = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) put_bit(1'b1);
    reset_n = 1'b0;
    #2;
    check("midrst_data_out", data_out, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    send_word(1'b1, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
    check("after_rst_data_out", data_out, 8'hA5);
    check("after_rst_valid", data_valid, 1);
    consume();

    // A bit_valid in the same cycle as start is not captured.
    send_word(1'b1, 8'h3C, 0, 1'b0, 1'b0, 1'b1);
    check("start_bv_data_out", data_out, 8'h3C);
    check("start_bv_valid", data_valid, 1);
    consume();

`ifdef SERIAL_CAPTURE_PARITY_EN
    // Completion happens on the parity bit. Good parity, then bad, then a dropped word.
    w = 8'hB2;
    start = 1'b1; msb_first = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) put_bit(w[i]);
    check("par_busy_after_8", busy, 1);
    check("par_valid_after_8", data_valid, 0);
    put_bit(1'b0);
    check("par_good_data_out", data_out, 8'hB2);
    check("par_good_valid", data_valid, 1);
    check("par_good_err", parity_err, 0);
    check("par_good_busy", busy, 0);
    consume();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) put_bit(w[i]);
    put_bit(1'b1);
    check("par_bad_err", parity_err, 1);
    check("par_bad_valid", data_valid, 1);
    send_word(1'b1, 8'h11, 0, 1'b0, 1'b0, 1'b0);
    check("par_drop_err_kept", parity_err, 1);
    check("par_drop_data_out", data_out, 8'hB2);
    check("par_drop_overrun", overrun, 1);
`else
    w = 8'h00;
    check("noparity_err_tied", parity_err, {24'd0, w});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
